// File: rtl/rice_encoder.sv
// Rice/Golomb encoder: unary quotient, '0' stop, k-bit remainder (or 32-bit escape),
// one bit per cycle into a 32-bit MSB-first packer; stalls only when the word slot is full.
module rice_encoder #(
  parameter int QLIMIT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  k,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, UNARY, STOP, REM, ESC, FLUSH} state_t;

  localparam logic [5:0] QL = 6'(QLIMIT);

  state_t      state, state_nx;
  logic [31:0] data_r;
  logic [3:0]  k_r;
  logic [5:0]  urem;
  logic        esc_r;
  logic [4:0]  idx;
  logic [31:0] acc;
  logic [4:0]  count;

  logic [31:0] q;
  logic        q_esc;
  logic [5:0]  q_len;
  logic        accept, start_flush, bit_pend, bit_val, stall, emit, word_done;

  assign q     = in_data >> k;
  assign q_esc = q >= 32'(QLIMIT);
  assign q_len = q_esc ? QL : q[5:0];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // A zero quotient spends no cycles in UNARY, so accept goes straight to STOP.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept)           state_nx = (q_len == 6'd0) ? STOP : UNARY;
        else if (start_flush) state_nx = FLUSH;
      end
      UNARY: if (emit && urem == 6'd1) state_nx = esc_r ? ESC : STOP;
      STOP:  if (emit) state_nx = (k_r != 4'd0) ? REM : IDLE;
      REM:   if (emit && idx == 5'd0) state_nx = IDLE;
      ESC:   if (emit && idx == 5'd0) state_nx = IDLE;
      FLUSH: if (emit && count == 5'd31) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = reset && (state == IDLE);
    busy        = reset && (state != IDLE);
    accept      = in_valid && in_ready;
    start_flush = in_ready && !in_valid && flush && (count != 5'd0);
    bit_pend    = (state != IDLE);
    case (state)
      UNARY:    bit_val = 1'b1;
      REM, ESC: bit_val = data_r[idx];
      default:  bit_val = 1'b0;
    endcase
    // Only the word-completing bit needs the output slot to be free.
    stall     = (count == 5'd31) && out_valid && !out_ready;
    emit      = bit_pend && !stall;
    word_done = emit && (count == 5'd31);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_r <= '0;
      k_r    <= '0;
      urem   <= '0;
      esc_r  <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      data_r <= in_data;
      k_r    <= k;
      urem   <= q_len;
      esc_r  <= q_esc;
      idx    <= 5'd31;
    end else if (emit) begin
      case (state)
        UNARY:    urem <= urem - 6'd1;
        STOP:     idx  <= 5'(k_r) - 5'd1;
        REM, ESC: idx  <= idx - 5'd1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc       <= '0;
      count     <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (emit) begin
        acc   <= {acc[30:0], bit_val};
        count <= count + 5'd1;
      end
      if (word_done) begin
        out_word  <= {acc[30:0], bit_val};
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  a_hold_word: assert property (@(posedge clk) disable iff (!reset)
    out_valid && !out_ready |=> out_valid && $stable(out_word));

endmodule

// File: tb/tb_rice_encoder.sv
// Directed bench for rice_encoder: each task drives one scenario and checks inline.
module tb_rice_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  k = '0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rice_encoder #(.QLIMIT(32)) dut (
    .clk(clk), .reset(reset), .k(k), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_word(out_word), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL rst_out_word got %h exp 00000000", out_word); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic_flush();
    int nv = 0, first = 0;
    logic [31:0] w = '0;
    logic early = 1'b0;
    out_ready = 1'b1;
    k = 4'd2; in_data = 32'd13; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; k = 4'd7; in_data = 32'hFFFF_FFFF;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got busy=%b rdy=%b exp 1/0", busy, in_ready); end
    for (int i = 0; i < 6; i++) begin
      flush = 1'b1;
      tick();
      if (out_valid) early = 1'b1;
    end
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || early !== 1'b0) begin errors++; $display("FAIL basic_six_cycles got busy=%b early_word=%b exp 0/0", busy, early); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_flush_enter got busy=%b exp 1", busy); end
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) begin nv++; w = out_word; if (first == 0) first = i; end
    end
    checks++; if (nv !== 1) begin errors++; $display("FAIL basic_word_count got %0d exp 1", nv); end
    checks++; if (w !== 32'hE400_0000) begin errors++; $display("FAIL basic_word got %h exp E4000000", w); end
    checks++; if (first !== 26) begin errors++; $display("FAIL basic_word_cycle got %0d exp 26", first); end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0, nw = 0, acc_at_word = 0;
    logic [31:0] w = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    k = 4'd0; in_data = 32'd0; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_valid && in_ready) n_acc++;
      tick();
      if (out_valid) begin nw++; w = out_word; acc_at_word = n_acc; end
      if (n_acc == 32) in_valid = 1'b0;
    end
    checks++; if (nw !== 1) begin errors++; $display("FAIL b2b_word_count got %0d exp 1", nw); end
    checks++; if (w !== 32'h0) begin errors++; $display("FAIL b2b_word got %h exp 00000000", w); end
    checks++; if (acc_at_word !== 32) begin errors++; $display("FAIL b2b_word_after got %0d accepts exp 32", acc_at_word); end
  endtask

  task automatic test_escape();
    int nw = 0, c1 = 0, c2 = 0;
    logic [31:0] w1 = '0, w2 = '0;
    out_ready = 1'b1;
    k = 4'd0; in_data = 32'd40; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (out_valid) begin
        nw++;
        if (nw == 1) begin w1 = out_word; c1 = i; end
        else begin w2 = out_word; c2 = i; end
      end
    end
    checks++; if (nw !== 2) begin errors++; $display("FAIL esc_word_count got %0d exp 2", nw); end
    checks++; if (w1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL esc_word1 got %h exp FFFFFFFF", w1); end
    checks++; if (w2 !== 32'h0000_0028) begin errors++; $display("FAIL esc_word2 got %h exp 00000028", w2); end
    checks++; if (c1 !== 32 || c2 !== 64) begin errors++; $display("FAIL esc_timing got %0d/%0d exp 32/64", c1, c2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL esc_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    k = 4'd0; in_data = 32'd40; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (80) tick();
    checks++; if (out_valid !== 1'b1 || out_word !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bp_held got v=%b w=%h exp 1/FFFFFFFF", out_valid, out_word); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_stall_busy got %b exp 1", busy); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_word !== 32'h0000_0028) begin errors++; $display("FAIL bp_release_word got %h exp 00000028", out_word); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid got %b exp 1", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b busy=%b exp 0/0", out_valid, busy); end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    logic [31:0] w = '0;
    out_ready = 1'b1;
    k = 4'd0; in_data = 32'd40; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_word !== 32'h0) begin errors++; $display("FAIL mid_rst_out got v=%b w=%h exp 0/00000000", out_valid, out_word); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got busy=%b rdy=%b exp 0/0", busy, in_ready); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_release got %b exp 1", in_ready); end
    k = 4'd1; in_data = 32'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) begin nv++; w = out_word; end
    end
    checks++; if (nv !== 1) begin errors++; $display("FAIL mid_word_count got %0d exp 1", nv); end
    checks++; if (w !== 32'h4000_0000) begin errors++; $display("FAIL mid_word got %h exp 40000000", w); end
  endtask

  task automatic test_flush_empty();
    logic saw_valid = 1'b0, saw_busy = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) flush = 1'b0;
      tick();
      if (out_valid !== 1'b0) saw_valid = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL empty_flush_valid got %b exp 0", saw_valid); end
    checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL empty_flush_busy got %b exp 0", saw_busy); end
  endtask

  initial begin
    test_reset();
    test_basic_flush();
    test_back_to_back();
    test_escape();
    test_backpressure();
    test_reset_mid();
    test_flush_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
